regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single 32x32 register-file write port among NUM_REQ requesters.
//  Accepts one valid/ready write per cycle and registers the winner onto rf_wr_* (1-cycle latency).
//  Writes to register 0 are consumed but never issued (r0 is hardwired zero).
//  Sits between the datapath write sources (ALU, load unit, etc.) and the register file write port.
// PARAMETERS
//  NUM_REQ     4   number of requesters (2..8)
//  DATA_WIDTH  32  write data width
//  ADDR_WIDTH  5   register address width (32 registers)
// PORTS
//  clk          in   1                     clock, all state updates on rising edge
//  rst_n        in   1                     synchronous reset, active low
//  enable       in   1                     1 = write port available; 0 = grant nothing
//  req_valid    in   NUM_REQ               per-requester write request
//  req_ready    out  NUM_REQ               per-requester accept (combinational)
//  req_addr     in   NUM_REQ*ADDR_WIDTH    requester i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  req_data     in   NUM_REQ*DATA_WIDTH    requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  rf_wr_en     out  1                     register-file write enable (registered)
//  rf_wr_addr   out  ADDR_WIDTH            register-file write address (registered)
//  rf_wr_data   out  DATA_WIDTH            register-file write data (registered)
//  grant_id     out  clog2(NUM_REQ)        index of last accepted requester (registered)
// BEHAVIOUR
//  - Single clock domain. Reset is synchronous, active-low; rst_n=0 at an edge applies reset.
//  - Reset: rf_wr_en=0, rf_wr_addr=0, rf_wr_data=0, grant_id=0, priority pointer ptr=0 (req 0 highest).
//    req_ready=0 whenever rst_n=0, so no transfer completes in a reset cycle; any pending output is cleared.
//  - Arbitration (combinational): scan i = ptr, ptr+1, ... mod NUM_REQ; first i with req_valid[i]=1 wins.
//    req_ready[win]=1 iff enable=1 and rst_n=1; all other req_ready bits = 0 (one-hot or zero).
//  - Transfer: req_valid[i] & req_ready[i] at a rising edge. At most one transfer per cycle.
//  - Next edge after a transfer from requester w:
//    rf_wr_addr<=addr[w], rf_wr_data<=data[w], grant_id<=w, ptr<=(w+1) mod NUM_REQ;
//    rf_wr_en<=1 if addr[w]!=0, else 0 (r0 write dropped but still acknowledged, ptr still advances).
//  - No transfer (no valid or enable=0): rf_wr_en<=0; rf_wr_addr/rf_wr_data/grant_id/ptr hold.
//  - Latency: accept at edge N -> rf_wr_en high for exactly the cycle after edge N; back-to-back
//    transfers give continuous rf_wr_en with no bubble.
//  - Fairness: a requester holding valid is granted within NUM_REQ accepting cycles.
//  - Requesters must hold valid/addr/data stable until accepted; the arbiter does not buffer unaccepted requests.
//  - enable dropping mid-stream: ready deasserts the same cycle; ptr is preserved and the round-robin
//    order resumes unchanged when enable returns.
// TESTING
//  1 Reset: rst_n=0 with all req_valid=1 -> req_ready=0; after edge rf_wr_en=0, grant_id=0, outputs 0.
//  2 Single: req_valid=4'b0100, addr2=5'd7, data2=32'hDEADBEEF -> ready=4'b0100; next cycle
//    rf_wr_en=1, addr=7, data=DEADBEEF, grant_id=2.
//  3 Round-robin: all four valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; rf_wr_en high 8 cycles.
//  4 r0 drop: req 1 valid with addr=0, data=32'h1 -> ready=4'b0010; next cycle rf_wr_en=0, grant_id=1.
//  5 enable gating: all valid, enable=0 for 3 cycles after granting 1 -> ready=0, rf_wr_en=0;
//    on enable=1 the next grant is 2.
//  6 Reset mid-stream: rst_n=0 during continuous grants -> next cycle rf_wr_en=0, ptr=0; first grant is 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Purpose: round-robin arbiter sharing the single register-file write port among NUM_REQ writers.
// Latency: 1 cycle from accept (valid & ready at an edge) to rf_wr_* driving the register file.
// Backpressure: req_ready is combinational, one-hot or zero, low while enable=0 or rst_n=0.
//
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   enable                write port available; 0 grants nothing
//   req_valid/req_ready   per-requester handshake (ready[i] = requester i wins this cycle)
//   req_addr/req_data     packed per-requester address/data, requester i at [i*W +: W]
//   rf_wr_en/addr/data    registered register-file write port (r0 writes never raise rf_wr_en)
//   grant_id              registered index of the most recently accepted requester
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          rf_wr_en,
  output logic [ADDR_WIDTH-1:0]         rf_wr_addr,
  output logic [DATA_WIDTH-1:0]         rf_wr_data,
  output logic [IDW-1:0]                grant_id
);

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NUM_REQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);

  logic [IDW-1:0]        r_ptr;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [IDW-1:0]        r_grant_id;

  logic                  w_found;
  logic [IDW-1:0]        w_win;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic [IDW-1:0]        w_ptr_next;

  // Rotating priority scan starting at r_ptr. The sum is one bit wider than
  // the index so the modulo wrap is a single conditional subtract.
  always_comb begin
    logic [IDW:0] w_sum;
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= NREQ_W) begin
        w_sum = w_sum - NREQ_W;
      end
      if (!w_found && req_valid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && enable && w_found) begin
      req_ready[w_win] = 1'b1;
    end
  end

  // The winner's valid is known high, so any ready bit means a transfer.
  assign w_xfer     = |req_ready;
  assign w_win_addr = req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_win_data = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
  assign w_ptr_next = (w_win == LAST_ID) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_grant_id <= '0;
    end else if (w_xfer) begin
      r_ptr      <= w_ptr_next;
      // r0 is hardwired zero: the write is acknowledged but never issued.
      r_wr_en    <= (w_win_addr != '0);
      r_wr_addr  <= w_win_addr;
      r_wr_data  <= w_win_data;
      r_grant_id <= w_win;
    end else begin
      r_wr_en <= 1'b0;
    end
  end

  assign rf_wr_en   = r_wr_en;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_wr_data;
  assign grant_id   = r_grant_id;

endmodule
